// File: rtl/ebr_host_if.sv
// Host-side command and read-stream bundle for ebr_host_port.
// master = host/driver side, slave = ebr_host_port.
interface ebr_host_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_we;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_len;
   logic [7:0] cmd_wdata;
   logic       wr_done;
   logic       wr_err;
   logic       rd_valid;
   logic       rd_ready;
   logic [7:0] rd_data;
   logic       rd_last;

   modport master (
      output cmd_valid, cmd_we, cmd_addr,
      output cmd_len, cmd_wdata, rd_ready,
      input  cmd_ready, wr_done, wr_err,
      input  rd_valid, rd_data, rd_last
   );

   modport slave (
      input  cmd_valid, cmd_we, cmd_addr,
      input  cmd_len, cmd_wdata, rd_ready,
      output cmd_ready, wr_done, wr_err,
      output rd_valid, rd_data, rd_last
   );
endinterface

// File: rtl/ebr_host_port.sv
// Host port onto EBR port A: single-byte writes, buffered burst reads.
// Optional write protection below WP_LIMIT: define EBR_HOST_WRPROT_EN.
module ebr_host_port #(
   parameter int         RD_LAT     = 2,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] WP_LIMIT   = 8'h10
) (
   input  logic       clk,
   input  logic       rst,
   ebr_host_if.slave  h,
   output logic [7:0] ebr_addr,
   output logic [7:0] ebr_din,
   output logic       ebr_wr,
   input  logic [7:0] ebr_q
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

`ifdef EBR_HOST_WRPROT_EN
   localparam bit WP_EN = 1'b1;
`else
   localparam bit WP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE, WRITE, READ, DRAIN
   } state_t;

   state_t     state;
   logic       cmd_ready_q;
   logic       wr_done_q;
   logic       rd_valid_q;
   logic       rd_last_q;
   logic [7:0] rd_data_q;
   logic [7:0] left;

   // vp[k]: a read issued k cycles ago is in flight; vl marks the last one
   logic [RD_LAT:0] vp;
   logic [RD_LAT:0] vl;

   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] cnt;

   logic          accept;
   logic          wp_hit;
   logic          push;
   logic          pop;
   logic          can_issue;
   logic          issue;
   logic          issue_last;
   logic [AW-1:0] rptr_n;
   logic [CW-1:0] cnt_n;
   logic [8:0]    head_n;
   int            occ;

   assign accept = h.cmd_valid & cmd_ready_q;
   assign wp_hit = WP_EN && (h.cmd_addr < WP_LIMIT);
   assign push   = vp[RD_LAT];
   assign pop    = rd_valid_q & h.rd_ready;

   always_comb begin
      occ = int'(cnt);
      for (int i = 0; i <= RD_LAT; i++)
         occ += int'(vp[i]);
      can_issue = occ < FIFO_DEPTH;
   end

   always_comb begin
      issue      = 1'b0;
      issue_last = 1'b0;
      if (state == IDLE && accept && !h.cmd_we) begin
         issue      = 1'b1;
         issue_last = h.cmd_len == 8'd0;
      end else if (state == READ && left != 8'd0
                   && can_issue) begin
         issue      = 1'b1;
         issue_last = left == 8'd1;
      end
   end

   // The pushed byte goes straight to the head when nothing older remains
   always_comb begin
      rptr_n = rptr + AW'(pop);
      cnt_n  = cnt + CW'(push) - CW'(pop);
      if (push && (cnt - CW'(pop)) == '0)
         head_n = {vl[RD_LAT], ebr_q};
      else
         head_n = mem[rptr_n];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cmd_ready_q <= 1'b0;
         wr_done_q   <= 1'b0;
         ebr_wr      <= 1'b0;
         ebr_addr    <= 8'd0;
         ebr_din     <= 8'd0;
         left        <= 8'd0;
      end else begin
         wr_done_q <= 1'b0;
         ebr_wr    <= 1'b0;
         unique case (state)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (accept) begin
                  cmd_ready_q <= 1'b0;
                  ebr_addr    <= h.cmd_addr;
                  if (h.cmd_we) begin
                     ebr_din   <= h.cmd_wdata;
                     ebr_wr    <= !wp_hit;
                     wr_done_q <= 1'b1;
                     state     <= WRITE;
                  end else begin
                     left  <= h.cmd_len;
                     state <= READ;
                  end
               end
            end
            WRITE: begin
               cmd_ready_q <= 1'b1;
               state       <= IDLE;
            end
            READ: begin
               if (left == 8'd0) begin
                  state <= DRAIN;
               end else if (can_issue) begin
                  ebr_addr <= ebr_addr + 8'd1;
                  left     <= left - 8'd1;
                  if (left == 8'd1)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && rd_last_q) begin
                  cmd_ready_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef EBR_HOST_WRPROT_EN
   logic wr_err_q;

   always_ff @(posedge clk) begin
      if (rst)
         wr_err_q <= 1'b0;
      else
         wr_err_q <= state == IDLE && accept
                     && h.cmd_we && wp_hit;
   end

   assign h.wr_err = wr_err_q;
`else
   assign h.wr_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         vp <= '0;
         vl <= '0;
      end else begin
         vp <= {vp[RD_LAT-1:0], issue};
         vl <= {vl[RD_LAT-1:0], issue_last};
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= {vl[RD_LAT], ebr_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr       <= '0;
         rptr       <= '0;
         cnt        <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'd0;
         rd_last_q  <= 1'b0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);
         rptr       <= rptr_n;
         cnt        <= cnt_n;
         rd_valid_q <= cnt_n != '0;
         if (cnt_n != '0)
            {rd_last_q, rd_data_q} <= head_n;
         else
            {rd_last_q, rd_data_q} <= 9'd0;
      end
   end

   assign h.cmd_ready = cmd_ready_q;
   assign h.wr_done   = wr_done_q;
   assign h.rd_valid  = rd_valid_q;
   assign h.rd_data   = rd_data_q;
   assign h.rd_last   = rd_last_q;

endmodule

// File: tb/tb_ebr_host_port.sv
// Directed bench for ebr_host_port with a 2-cycle EBR read model.
// Expected values are hand-derived from memory contents mem[a]=a.
module tb_ebr_host_port;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ebr_addr;
   logic [7:0] ebr_din;
   logic       ebr_wr;
   logic [7:0] ebr_q;

   ebr_host_if h ();

   ebr_host_port dut (
      .clk      (clk),
      .rst      (rst),
      .h        (h),
      .ebr_addr (ebr_addr),
      .ebr_din  (ebr_din),
      .ebr_wr   (ebr_wr),
      .ebr_q    (ebr_q)
   );

   always #5 clk = ~clk;

   // EBR model: address in cycle t, data on q in cycle t+2
   logic [7:0] mem [256];
   logic [7:0] a1;
   logic [7:0] q;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++)
            mem[i] <= 8'(i);
      end else if (ebr_wr) begin
         mem[ebr_addr] <= ebr_din;
      end
      a1 <= ebr_addr;
      q  <= mem[a1];
   end

   assign ebr_q = q;

   int total = 0;
   int bad   = 0;

   logic [7:0] got_d [32];
   logic       got_l [32];
   int         got_c [32];
   int         n;
   int         first;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
      end
   endtask

   task automatic send(input logic       we,
                       input logic [7:0] a,
                       input logic [7:0] len,
                       input logic [7:0] wd);
      int w;
      h.cmd_valid = 1'b1;
      h.cmd_we    = we;
      h.cmd_addr  = a;
      h.cmd_len   = len;
      h.cmd_wdata = wd;
      for (w = 0; w < 50; w++) begin
         @(negedge clk);
         if (h.cmd_ready)
            break;
      end
      chk("cmd_accept", 32'(w < 50), 32'd1);
      @(posedge clk);
      #1 h.cmd_valid = 1'b0;
   endtask

   // Cycle 1 is the first cycle after the accept edge
   task automatic collect(input int budget,
                          input int stop_at,
                          output int cnt,
                          output int fst);
      cnt = 0;
      fst = -1;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (h.rd_valid && fst < 0)
            fst = c;
         if (h.rd_valid && h.rd_ready && cnt < 32) begin
            got_d[cnt] = h.rd_data;
            got_l[cnt] = h.rd_last;
            got_c[cnt] = c;
            cnt++;
            if (h.rd_last || cnt == stop_at)
               return;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      h.cmd_valid = 1'b0;
      h.cmd_we    = 1'b0;
      h.cmd_addr  = 8'd0;
      h.cmd_len   = 8'd0;
      h.cmd_wdata = 8'd0;
      h.rd_ready  = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", 32'(h.cmd_ready), 0);
      chk("rst_rd_valid", 32'(h.rd_valid), 0);
      chk("rst_rd_data", 32'(h.rd_data), 0);
      chk("rst_ebr_wr", 32'(ebr_wr), 0);
      chk("rst_ebr_addr", 32'(ebr_addr), 0);
      chk("rst_wr_done", 32'(h.wr_done), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rel_cmd_ready", 32'(h.cmd_ready), 1);

      // single write
      send(1'b1, 8'h20, 8'd0, 8'hA5);
      @(negedge clk);
      chk("wr_ebr_wr", 32'(ebr_wr), 1);
      chk("wr_ebr_addr", 32'(ebr_addr), 32'h20);
      chk("wr_ebr_din", 32'(ebr_din), 32'hA5);
      chk("wr_done", 32'(h.wr_done), 1);
      chk("wr_err", 32'(h.wr_err), 0);
      chk("wr_busy", 32'(h.cmd_ready), 0);
      @(negedge clk);
      chk("wr_ebr_wr_off", 32'(ebr_wr), 0);
      chk("wr_done_off", 32'(h.wr_done), 0);
      chk("wr_idle", 32'(h.cmd_ready), 1);

      // len 0 readback of the written byte
      h.rd_ready = 1'b1;
      send(1'b0, 8'h20, 8'd0, 8'd0);
      collect(30, 0, n, first);
      chk("rb_n", 32'(n), 1);
      chk("rb_data", 32'(got_d[0]), 32'hA5);
      chk("rb_last", 32'(got_l[0]), 1);
      chk("rb_drain", 32'(h.cmd_ready), 0);
      @(negedge clk);
      chk("rb_idle", 32'(h.cmd_ready), 1);

      // burst at 0x40, len 3
      send(1'b0, 8'h40, 8'd3, 8'd0);
      collect(40, 0, n, first);
      chk("b40_n", 32'(n), 4);
      chk("b40_first", 32'(first), 4);
      for (int i = 0; i < 4; i++) begin
         chk("b40_data", 32'(got_d[i]), 32'(8'h40 + i));
         chk("b40_last", 32'(got_l[i]), 32'(i == 3));
      end
      chk("b40_span", 32'(got_c[3] - got_c[0]), 3);
      @(negedge clk);
      chk("b40_idle", 32'(h.cmd_ready), 1);

      // address wrap FE,FF,00,01
      send(1'b0, 8'hFE, 8'd3, 8'd0);
      collect(40, 0, n, first);
      chk("wrap_n", 32'(n), 4);
      chk("wrap_d0", 32'(got_d[0]), 32'hFE);
      chk("wrap_d1", 32'(got_d[1]), 32'hFF);
      chk("wrap_d2", 32'(got_d[2]), 32'h00);
      chk("wrap_d3", 32'(got_d[3]), 32'h01);
      chk("wrap_last", 32'(got_l[3]), 1);
      chk("wrap_nlast", 32'(got_l[2]), 0);

      // back-pressure: len 9, rd_ready low 20 cycles
      @(posedge clk);
      #1 h.rd_ready = 1'b0;
      send(1'b0, 8'h60, 8'd9, 8'd0);
      repeat (10) @(negedge clk);
      chk("bp_data_a", 32'(h.rd_data), 32'h60);
      repeat (10) @(negedge clk);
      chk("bp_issue_cap", 32'(ebr_addr), 32'h63);
      chk("bp_valid", 32'(h.rd_valid), 1);
      chk("bp_data_b", 32'(h.rd_data), 32'h60);
      chk("bp_last", 32'(h.rd_last), 0);
      @(posedge clk);
      #1 h.rd_ready = 1'b1;
      collect(80, 0, n, first);
      chk("bp_n", 32'(n), 10);
      for (int i = 0; i < 10; i++) begin
         chk("bp_seq", 32'(got_d[i]), 32'(8'h60 + i));
         chk("bp_lastf", 32'(got_l[i]), 32'(i == 9));
      end

      // reset after the 2nd byte of a len-7 burst
      @(posedge clk);
      send(1'b0, 8'h80, 8'd7, 8'd0);
      collect(40, 2, n, first);
      chk("mid_n", 32'(n), 2);
      chk("mid_d1", 32'(got_d[1]), 32'h81);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rd_valid", 32'(h.rd_valid), 0);
      chk("mid_rd_data", 32'(h.rd_data), 0);
      chk("mid_rd_last", 32'(h.rd_last), 0);
      chk("mid_ebr_addr", 32'(ebr_addr), 0);
      chk("mid_ebr_wr", 32'(ebr_wr), 0);
      chk("mid_cmd_ready", 32'(h.cmd_ready), 0);
      @(negedge clk);
      chk("mid_ready_up", 32'(h.cmd_ready), 1);
      send(1'b0, 8'hA0, 8'd1, 8'd0);
      collect(40, 0, n, first);
      chk("post_n", 32'(n), 2);
      chk("post_d0", 32'(got_d[0]), 32'hA0);
      chk("post_d1", 32'(got_d[1]), 32'hA1);
      chk("post_last", 32'(got_l[1]), 1);

      // write protection boundary
      @(posedge clk);
      send(1'b1, 8'h05, 8'd0, 8'h3C);
      @(negedge clk);
      chk("wp_done", 32'(h.wr_done), 1);
`ifdef EBR_HOST_WRPROT_EN
      chk("wp_wr", 32'(ebr_wr), 0);
      chk("wp_err", 32'(h.wr_err), 1);
`else
      chk("wp_wr", 32'(ebr_wr), 1);
      chk("wp_err", 32'(h.wr_err), 0);
`endif
      @(posedge clk);
      send(1'b1, 8'h10, 8'd0, 8'hC3);
      @(negedge clk);
      chk("wp10_wr", 32'(ebr_wr), 1);
      chk("wp10_err", 32'(h.wr_err), 0);
      @(posedge clk);
      send(1'b0, 8'h05, 8'd0, 8'd0);
      collect(30, 0, n, first);
      chk("wp_rb_n", 32'(n), 1);
`ifdef EBR_HOST_WRPROT_EN
      chk("wp_rb", 32'(got_d[0]), 32'h05);
`else
      chk("wp_rb", 32'(got_d[0]), 32'h3C);
`endif
      @(posedge clk);
      send(1'b0, 8'h10, 8'd0, 8'd0);
      collect(30, 0, n, first);
      chk("wp10_rb", 32'(got_d[0]), 32'hC3);

      $display("test done: total=%0d bad=%0d",
               total, bad);
      $finish;
   end

endmodule

// File: doc/ebr_host_port.md
EBR_HOST_PORT -- requirements
Module: ebr_host_port

Interface
REQ-001 Parameter RD_LAT, default 2: read latency of the EBR port-A Q output in clk cycles, counted from address presentation.
REQ-002 Parameter FIFO_DEPTH, default 4: read-data buffer entries; must be a power of two, at least 2.
REQ-003 Parameter WP_LIMIT, default 8'h10: first writable address when write protection is compiled in.
REQ-004 clk  in  1  the single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 cmd_valid  in  1  host command present.
REQ-007 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-008 cmd_we  in  1  1 = single-byte write, 0 = burst read.
REQ-009 cmd_addr  in  8  start address.
REQ-010 cmd_len  in  8  burst length minus 1 (reads only).
REQ-011 cmd_wdata  in  8  write data.
REQ-012 wr_done  out  1  one-cycle pulse when a write completes or is dropped.
REQ-013 wr_err  out  1  one-cycle pulse with wr_done when a write is dropped.
REQ-014 rd_valid / rd_ready  out / in  1 / 1  read-data stream handshake.
REQ-015 rd_data  out  8  read byte.
REQ-016 rd_last  out  1  marks the final byte of the burst.
REQ-017 ebr_addr / ebr_din / ebr_wr  out  8 / 8 / 1  EBR port-A address, write data, write strobe (the port opposite the I2C slave).
REQ-018 ebr_q  in  8  EBR port-A read data.

Function
REQ-019 The FSM SHALL have the states IDLE, WRITE, READ and DRAIN; cmd_ready SHALL be high only in IDLE.
REQ-020 An accept in IDLE with cmd_we=1 SHALL latch the address and data and enter WRITE.
REQ-021 WRITE SHALL last exactly one cycle: ebr_wr=1, ebr_addr/ebr_din = latched values, wr_done=1; the next state is IDLE.
REQ-022 An accept with cmd_we=0 SHALL latch addr and len and enter READ; the first address is issued the cycle after accept.
REQ-023 READ SHALL issue one address per cycle, but only while (outstanding reads + FIFO occupancy) < FIFO_DEPTH.
REQ-024 Issued addresses SHALL increment modulo 256 (8'hFF is followed by 8'h00); len+1 addresses are issued in total, len=8'hFF giving 256.
REQ-025 Each issued read SHALL be captured from ebr_q exactly RD_LAT cycles after issue, tagged with last = (final issue), and pushed into the FIFO.
REQ-026 The FIFO SHALL never overflow; rd_valid SHALL be registered and asserted the cycle after a push into an empty FIFO. Minimum latency: accept at cycle 0 gives rd_valid at cycle RD_LAT+2.
REQ-027 A byte SHALL pop on rd_valid && rd_ready; rd_data and rd_last SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-028 Push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-029 After the final issue the FSM SHALL enter DRAIN, then return to IDLE the cycle after the rd_last byte pops.
REQ-030 ebr_wr SHALL be 0 in every state except WRITE; ebr_addr SHALL hold its last value when idle.

Reset
REQ-031 While rst=1: state=IDLE, cmd_ready=0, wr_done=0, wr_err=0, rd_valid=0, rd_data=0, rd_last=0, ebr_wr=0, ebr_addr=0, ebr_din=0.
REQ-032 Reset mid-burst SHALL flush the FIFO, discard in-flight reads and clear the outstanding counter; no stale data appears after reset.
REQ-033 cmd_ready SHALL rise the first cycle after rst deasserts.

Configuration
REQ-034 Macro EBR_HOST_WRPROT_EN: when defined, a write with cmd_addr < WP_LIMIT SHALL keep ebr_wr=0 and pulse wr_done=1 and wr_err=1 in the WRITE cycle.
REQ-035 When EBR_HOST_WRPROT_EN is undefined, all addresses SHALL be writable and wr_err SHALL be tied to 0.

Verification
REQ-036 Write addr 8'h20, data 8'hA5 -> one cycle later ebr_wr=1, ebr_addr=8'h20, ebr_din=8'hA5, wr_done=1; back in IDLE the next cycle.
REQ-037 Read addr 8'h40, len 3, rd_ready=1, memory holds 8'h40+i -> bytes 40,41,42,43 on consecutive cycles, rd_last on 43, first rd_valid at cycle 4.
REQ-038 Read addr 8'hFE, len 3 -> addresses FE,FF,00,01 issued in that order, rd_last on the byte from 01.
REQ-039 Read len 9 with rd_ready=0 for 20 cycles -> at most 4 reads outstanding or buffered, no data lost, all 10 bytes in order once rd_ready=1.
REQ-040 rst=1 for 1 cycle after the 2nd byte of a len-7 burst -> all outputs zero, cmd_ready=1 the next cycle, a new read returns correct data.
REQ-041 With EBR_HOST_WRPROT_EN, write addr 8'h05 -> ebr_wr stays 0, wr_done=1 and wr_err=1; write addr 8'h10 succeeds with wr_err=0.
